// File: rtl/seq_divider.sv
// seq_divider: restoring radix-2 unsigned divider, one quotient bit per clock.
// Optional DIV_ROUND_EN adds a ROUND cycle that rounds the quotient half-up.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] dividerres,
  output logic [WIDTH-1:0] remainder,
  output logic             Busy,
  output logic             Ready,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, ROUND} state_t;
  state_t state_q, state_d;
  logic [WIDTH:0] rem_q, rem_d, rem_n;
  logic [WIDTH-1:0] quo_q, quo_d, quo_n, dvs_q, dvs_d, res_q, res_d, remo_q, remo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rdy_q, rdy_d, dz_q, dz_d, ge, last;
  logic [WIDTH+1:0] rem_sh, diff;
`ifdef DIV_ROUND_EN
  logic rnd;
  logic [WIDTH-1:0] quo_inc;
`endif
  always_comb begin
    // quo_q holds the unconsumed dividend bits on top and the quotient bits below
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff = rem_sh - {2'b0, dvs_q};
    ge = ~diff[WIDTH+1];
    rem_n = ge ? diff[WIDTH:0] : rem_sh[WIDTH:0];
    quo_n = {quo_q[WIDTH-2:0], ge};
    last = cnt_q == CW'(WIDTH - 1);
`ifdef DIV_ROUND_EN
    rnd = {rem_q, 1'b0} >= {2'b0, dvs_q};
    quo_inc = &quo_q ? quo_q : quo_q + 1'b1;
`endif
    state_d = state_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    res_d = res_q;
    remo_d = remo_q;
    rdy_d = rdy_q;
    dz_d = dz_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        quo_d = dividend;
        dvs_d = divisor;
        rem_d = '0;
        cnt_d = '0;
        rdy_d = 1'b0;
        dz_d = 1'b0;
      end
      RUN: if (dvs_q == '0) begin
        state_d = IDLE;
        res_d = '1;
        remo_d = quo_q;
        dz_d = 1'b1;
        rdy_d = 1'b1;
      end else begin
        rem_d = rem_n;
        quo_d = quo_n;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
`ifdef DIV_ROUND_EN
          state_d = ROUND;
`else
          state_d = IDLE;
          res_d = quo_n;
          remo_d = rem_n[WIDTH-1:0];
          rdy_d = 1'b1;
`endif
        end
      end
`ifdef DIV_ROUND_EN
      ROUND: begin
        state_d = IDLE;
        res_d = rnd ? quo_inc : quo_q;
        remo_d = rem_q[WIDTH-1:0];
        rdy_d = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      remo_q <= '0;
      rdy_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      remo_q <= remo_d;
      rdy_q <= rdy_d;
      dz_q <= dz_d;
    end
  end
  assign dividerres = res_q;
  assign remainder = remo_q;
  assign Busy = state_q != IDLE;
  assign Ready = rdy_q;
  assign div_zero = dz_q;
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Shared multi-cycle unsigned integer divider for the bike computer datapath.
- Sits directly downstream of the average-speed stage and other ratio stages: consumes their dividend/divisor and returns quotient with Busy/Ready status.
- Restoring radix-2 algorithm, one quotient bit per clock.
- Keeps the area small versus a combinational divider; throughput is irrelevant at display update rates.

Parameters:
- WIDTH, 16, bit width of dividend, divisor, quotient and remainder.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  request pulse; sampled only when Busy=0.
- dividend  in  WIDTH  numerator, sampled on accepted start.
- divisor  in  WIDTH  denominator, sampled on accepted start.
- dividerres  out  WIDTH  quotient, registered.
- remainder  out  WIDTH  remainder, registered.
- Busy  out  1  high while a division is in progress.
- Ready  out  1  high when dividerres/remainder hold a completed result.
- div_zero  out  1  last accepted division had divisor=0.

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-division): dividerres=0, remainder=0, Busy=0, Ready=0, div_zero=0, iteration counter=0, internal operand registers=0. Any in-flight operation is discarded.
- States: IDLE, RUN, (ROUND when DIV_ROUND_EN). "Done" is IDLE with Ready=1.
- IDLE, accept rule: edge k with start=1 and Busy=0.
  - Latches dividend and divisor.
  - Sets Busy=1, Ready=0, div_zero=0, counter=0.
  - Moves to RUN.
- start while Busy=1: ignored completely; operands are not re-sampled.
- start while Ready=1 and Busy=0: accepted normally; Ready drops on the same edge.
- RUN, per edge:
  - Partial remainder register is WIDTH+1 bits.
  - Shift left, bringing in the next dividend bit (MSB first).
  - Trial subtract divisor. If result ≥0, keep the difference and shift in quotient bit 1; else restore and shift in 0.
  - counter increments.
- Completion: on the WIDTH-th RUN edge (edge k+WIDTH):
  - dividerres and remainder are updated.
  - Busy=0, Ready=1, return to IDLE.
- Busy is high for exactly WIDTH cycles (16 by default). Results become visible at k+WIDTH.
- dividerres and remainder change only at completion or reset. They hold their previous values while Busy=1.
- Ready stays high until the next accepted start or reset. It is a level signal, not a pulse.
- Divide by zero (divisor=0 at accept):
  - No iteration is performed.
  - At edge k+1: dividerres = all ones (16'hFFFF), remainder = latched dividend, div_zero=1, Busy=0, Ready=1.
  - Busy is high for exactly 1 cycle, so upstream stages that wait for Busy to rise still see it.
- dividend=0 with nonzero divisor: normal WIDTH-cycle run; quotient 0, remainder 0.
- All arithmetic is unsigned. No overflow is possible except the divide-by-zero case.
- Busy and Ready are never both 1.

Optional Feature:
- Macro: DIV_ROUND_EN.
- Defined:
  - After the final RUN edge, enter ROUND for one cycle with Busy still 1.
  - If 2*remainder ≥ divisor, increment the quotient, saturating at all ones.
  - Reported remainder stays the truncated remainder.
  - Busy lasts WIDTH+1 cycles; results appear at k+WIDTH+1.
  - Divide-by-zero path is unchanged (1 cycle).
- Undefined: no ROUND state; truncating quotient; latency WIDTH.

Test Plan:
- Basic: reset release, start with dividend=36000, divisor=10 → Busy high exactly 16 cycles, then dividerres=3600, remainder=0, Ready=1, div_zero=0.
- Non-exact and zero-quotient cases:
  - 50000/7 → dividerres=7142, remainder=6.
  - 5/7 → dividerres=0, remainder=5.
  - 65535/1 → 65535, remainder 0.
- Divide by zero: 1234/0 → Busy high 1 cycle, then dividerres=16'hFFFF, remainder=1234, div_zero=1, Ready=1.
  - A following 100/3 clears div_zero and yields 33 rem 1.
- Start during Busy: start 1000/10, then pulse start with 9/3 at cycle 5 → ignored; result is 100 rem 0 at cycle 16.
  - A back-to-back start on the Ready cycle is accepted and Ready drops.
- Reset mid-operation: start 60000/3, drive rst=0 asynchronously at cycle 8 → all outputs 0 immediately.
  - After release, Busy stays 0 until a new start.
- Rounding, with DIV_ROUND_EN:
  - 10/4 → 3 with Busy 17 cycles.
  - 9/4 → 2.
  - 65535/2 → 32768.
  - Without the macro, 10/4 → 2 with Busy 16 cycles.
